pipe_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the shared 6-bit `stall` vector consumed by the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves stall requests from ID (load-use), EX (multi-cycle divider) and MEM (data-memory wait states), sequences the divider start/done handshake, and bounds memory waits with a timeout.

---
 rtl/pipe_ctrl_if.sv | 25 ++
 rtl/pipe_ctrl.sv | 86 ++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The pipeline side is the master; the controller is the slave.
interface pipe_ctrl_if;
  logic        idStallReq;
  logic        exMultiReq;
  logic        divDone;
  logic        memReq;
  logic        memReady;
  logic        flushReq;
  logic [5:0]  stall;
  logic        divStart;
  logic        flush;
  logic        memErr;
  logic [31:0] stallCount;

  modport master (
    output idStallReq, exMultiReq, divDone, memReq, memReady, flushReq,
    input  stall, divStart, flush, memErr, stallCount
  );

  modport slave (
    input  idStallReq, exMultiReq, divDone, memReq, memReady, flushReq,
    output stall, divStart, flush, memErr, stallCount
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: arbitrates ID/EX/MEM stall requests, launches
// the divider, bounds data-memory waits and counts PC-stalled cycles.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, EX_WAIT, MEM_WAIT} state_t;

  localparam logic [5:0]       STALL_ID  = 6'b000111;
  localparam logic [5:0]       STALL_EX  = 6'b001111;
  localparam logic [5:0]       STALL_MEM = 6'b011111;
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(MEM_TIMEOUT);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] wait_cnt, nxt_wait_cnt;
  logic [31:0]      stall_cnt;
  logic [5:0]       stall;
  logic             div_start, mem_err;

  // Deepest requesting stage wins; outputs are decoded in the request cycle.
  always_comb begin
    nxt_state    = state;
    nxt_wait_cnt = wait_cnt;
    stall        = '0;
    div_start    = 1'b0;
    mem_err      = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.memReq && !bus.memReady) begin
          stall        = STALL_MEM;
          nxt_wait_cnt = CNT_W'(1);
          nxt_state    = MEM_WAIT;
        end else if (bus.exMultiReq) begin
          stall     = STALL_EX;
          div_start = 1'b1;
          nxt_state = EX_WAIT;
        end else if (bus.idStallReq) begin
          stall = STALL_ID;
        end
      end
      EX_WAIT: begin
        if (bus.divDone) nxt_state = RUN;
        else             stall     = STALL_EX;
      end
      MEM_WAIT: begin
        // A response in the timeout cycle still counts as success.
        if (bus.memReady) begin
          stall     = bus.idStallReq ? STALL_ID : '0;
          nxt_state = RUN;
        end else if (wait_cnt == TIMEOUT) begin
          mem_err   = 1'b1;
          nxt_state = RUN;
        end else begin
          stall        = STALL_MEM;
          nxt_wait_cnt = wait_cnt + CNT_W'(1);
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= nxt_state;
      wait_cnt  <= nxt_wait_cnt;
      if (stall[0]) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Outputs are held low for the whole reset window, including before the first edge.
  assign bus.stall      = rst ? stall : '0;
  assign bus.divStart   = rst & div_start;
  assign bus.memErr     = rst & mem_err;
  assign bus.flush      = rst & bus.flushReq & ~stall[3];
  assign bus.stallCount = rst ? stall_cnt : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus random
// traffic compared every cycle against an operation-level reference model.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding long operation at a time, tracked by how
  // many cycles it has stalled the pipe so far.
  bit          m_div_busy;
  int          m_mem_stalled;  // 0 means no memory access is outstanding
  int unsigned m_cnt;
  logic [5:0]  e_stall;
  logic        e_div, e_flush, e_err;

  always @(negedge clk) begin
    e_stall = '0; e_div = 1'b0; e_flush = 1'b0; e_err = 1'b0;
    if (!rst) begin
      m_div_busy = 0; m_mem_stalled = 0; m_cnt = 0;
    end else begin
      if (m_mem_stalled > 0) begin
        if (bus.memReady) begin
          e_stall = bus.idStallReq ? 6'b000111 : 6'b000000;
          m_mem_stalled = 0;
        end else if (m_mem_stalled == TO) begin
          e_err = 1'b1;
          m_mem_stalled = 0;
        end else begin
          e_stall = 6'b011111;
          m_mem_stalled++;
        end
      end else if (m_div_busy) begin
        if (bus.divDone) m_div_busy = 0;
        else             e_stall = 6'b001111;
      end else if (bus.memReq && !bus.memReady) begin
        e_stall = 6'b011111;
        m_mem_stalled = 1;
      end else if (bus.exMultiReq) begin
        e_stall = 6'b001111;
        e_div = 1'b1;
        m_div_busy = 1;
      end else if (bus.idStallReq) begin
        e_stall = 6'b000111;
      end
      e_flush = bus.flushReq && !e_stall[3];
    end
    chk("model stall",      32'(bus.stall),    32'(e_stall));
    chk("model divStart",   32'(bus.divStart), 32'(e_div));
    chk("model flush",      32'(bus.flush),    32'(e_flush));
    chk("model memErr",     32'(bus.memErr),   32'(e_err));
    chk("model stallCount", bus.stallCount,    m_cnt);
    if (rst && e_stall[0]) m_cnt++;
  end

  task automatic drive(input logic id, ex, dd, mr, rdy, fl);
    bus.idStallReq = id; bus.exMultiReq = ex; bus.divDone = dd;
    bus.memReq = mr; bus.memReady = rdy; bus.flushReq = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1;
    // Reset with every request asserted
    drive(1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst stall", 32'(bus.stall), 32'h0);
      chk("rst divStart", 32'(bus.divStart), 32'h0);
      chk("rst flush", 32'(bus.flush), 32'h0);
      chk("rst memErr", 32'(bus.memErr), 32'h0);
      chk("rst stallCount", bus.stallCount, 32'h0);
    end
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();

    // Load-use with a simultaneous flush
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("loaduse stall", 32'(bus.stall), 32'h07);
    chk("loaduse flush", 32'(bus.flush), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("loaduse count", bus.stallCount, 32'd1);
    chk("loaduse release", 32'(bus.stall), 32'h0);
    next_cycle();

    // Divider: done arrives 5 cycles after start, flush held meanwhile
    drive(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("div start", 32'(bus.divStart), 32'h1);
    chk("div stall0", 32'(bus.stall), 32'h0f);
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      drive(0, 1, 0, 0, 0, 1);
      @(negedge clk);
      chk("div hold stall", 32'(bus.stall), 32'h0f);
      chk("div no restart", 32'(bus.divStart), 32'h0);
      chk("div flush deferred", 32'(bus.flush), 32'h0);
    end
    next_cycle();
    drive(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    chk("div done release", 32'(bus.stall), 32'h0);
    chk("div done flush", 32'(bus.flush), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("div count", bus.stallCount, 32'd6);
    next_cycle();

    // Memory: ready after 3 wait cycles, then a zero-wait access
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("mem wait stall", 32'(bus.stall), 32'h1f);
      next_cycle();
    end
    drive(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("mem ready stall", 32'(bus.stall), 32'h0);
    chk("mem ready err", 32'(bus.memErr), 32'h0);
    next_cycle();
    drive(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("mem zero-wait", 32'(bus.stall), 32'h0);
    next_cycle();

    // Timeout, then timeout cycle rescued by ready
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < TO; i++) begin
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("timeout stall", 32'(bus.stall), 32'h1f);
        next_cycle();
      end
      drive(0, 0, 0, 1, rep[0], 0);
      @(negedge clk);
      chk("timeout release", 32'(bus.stall), 32'h0);
      chk("timeout memErr", 32'(bus.memErr), rep == 0 ? 32'h1 : 32'h0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("timeout err pulse", 32'(bus.memErr), 32'h0);
      next_cycle();
    end

    // Priority: MEM over EX over ID; divider launches after MEM resolves
    drive(1, 1, 0, 1, 0, 0);
    @(negedge clk);
    chk("prio stall", 32'(bus.stall), 32'h1f);
    chk("prio no divStart", 32'(bus.divStart), 32'h0);
    next_cycle();
    drive(1, 1, 0, 1, 1, 0);
    @(negedge clk);
    chk("prio resolve stall", 32'(bus.stall), 32'h07);
    chk("prio resolve divStart", 32'(bus.divStart), 32'h0);
    next_cycle();
    drive(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("prio late divStart", 32'(bus.divStart), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0);
    next_cycle();

    // Reset during a divider wait aborts it
    drive(0, 1, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("abort stall", 32'(bus.stall), 32'h0);
    chk("abort divStart", 32'(bus.divStart), 32'h0);
    next_cycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) != 0);
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
            $urandom_range(1) == 0, $urandom_range(9) < 3, $urandom_range(4) == 0);
      next_cycle();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
